// File: rtl/im_loader.sv
// im_loader: boots a processor by streaming a program image into instruction memory.
//
// Stream format: 16-bit word count N (MSB byte first), then N 32-bit words (MSB byte
// first). Each assembled word is written to address 0..N-1. The processor reset stays
// asserted (cpu_rst_f low) until the whole image is loaded.
//
// Build option: define IM_LOADER_CSUM_EN to require one trailing checksum byte
// (XOR of all data bytes, header excluded). A mismatch ends in the error state.
// Without the macro there is no checksum logic and err is tied low.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_byte    in   [7:0] stream byte
//   in_valid   in   stream byte valid
//   in_ready   out  loader can accept a byte (transfer = in_valid & in_ready)
//   reload     in   restart request, honoured only in the done/error states
//   wr_en      out  instruction memory write strobe (one cycle per word)
//   wr_addr    out  [15:0] instruction memory word address
//   wr_data    out  [31:0] instruction word
//   cpu_rst_f  out  active-low processor reset, released only after a good load
//   done       out  load completed successfully
//   err        out  checksum mismatch (checksum build only)

module im_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reload,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_rst_f,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    StHdrHi = 3'd0,
    StHdrLo = 3'd1,
    StData  = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4,
    StErr   = 3'd5
`ifdef IM_LOADER_CSUM_EN
    ,
    StCsum  = 3'd6
`endif
  } state_e;

  // State entered once the last word (or an empty image) has been handled.
`ifdef IM_LOADER_CSUM_EN
  localparam state_e StFinish = StCsum;
`else
  localparam state_e StFinish = StDone;
`endif

  state_e      state_q, state_d;
  logic [15:0] n_q, n_d;               // word count from the header
  logic [15:0] word_cnt_q, word_cnt_d; // address of the word being assembled
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] asm_q, asm_d;           // first three bytes of the current word
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
`ifdef IM_LOADER_CSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic xfer;
  assign xfer = in_valid & in_ready;

  // Outputs decoded straight from the state register.
  always_comb begin
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    cpu_rst_f = 1'b0;
    err       = 1'b0;
    case (state_q)
      StHdrHi, StHdrLo, StData: in_ready = 1'b1;
`ifdef IM_LOADER_CSUM_EN
      StCsum:                   in_ready = 1'b1;
      StErr:                    err      = 1'b1;
`endif
      StWrite:                  wr_en    = 1'b1;
      StDone: begin
        done      = 1'b1;
        cpu_rst_f = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef IM_LOADER_CSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      StHdrHi: begin
        if (xfer) begin
          n_d[15:8] = in_byte;
          state_d   = StHdrLo;
        end
      end

      StHdrLo: begin
        if (xfer) begin
          n_d[7:0]   = in_byte;
          word_cnt_d = 16'd0;
          byte_idx_d = 2'd0;
          if ({n_q[15:8], in_byte} == 16'd0) begin
            state_d = StFinish;
          end else begin
            state_d = StData;
          end
        end
      end

      StData: begin
        if (xfer) begin
          asm_d      = {asm_q[15:0], in_byte};
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IM_LOADER_CSUM_EN
          csum_d     = csum_q ^ in_byte;
`endif
          // Word and address are captured on the 4th byte so they are stable
          // for the whole write cycle and held afterwards.
          if (byte_idx_q == 2'd3) begin
            wr_data_d = {asm_q, in_byte};
            wr_addr_d = word_cnt_q;
            state_d   = StWrite;
          end
        end
      end

      StWrite: begin
        if (word_cnt_q == n_q - 16'd1) begin
          state_d = StFinish;
        end else begin
          word_cnt_d = word_cnt_q + 16'd1;
          byte_idx_d = 2'd0;
          state_d    = StData;
        end
      end

`ifdef IM_LOADER_CSUM_EN
      StCsum: begin
        if (xfer) begin
          state_d = (in_byte == csum_q) ? StDone : StErr;
        end
      end
`endif

      StDone, StErr: begin
        if (reload) begin
          state_d    = StHdrHi;
          word_cnt_d = 16'd0;
          byte_idx_d = 2'd0;
`ifdef IM_LOADER_CSUM_EN
          csum_d     = 8'd0;
`endif
        end
      end

      default: state_d = StHdrHi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHdrHi;
      n_q        <= 16'd0;
      word_cnt_q <= 16'd0;
      byte_idx_q <= 2'd0;
      asm_q      <= 24'd0;
      wr_addr_q  <= 16'd0;
      wr_data_q  <= 32'd0;
`ifdef IM_LOADER_CSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef IM_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader (default build, checksum disabled). Streams are built as byte
// queues; a reference model turns each stream into the list of (address, word) writes
// it must produce, and a negedge monitor checks every write strobe against that list
// and against the cycle at which the word's last byte was accepted.

module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        reload;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst_f;
  logic        done;
  logic        err;

  im_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .reload    (reload),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_rst_f (cpu_rst_f),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic [7:0]  stream[$];
  wr_t         exp_q[$];
  int unsigned cyc_q[$];  // cycle at which each write strobe must be seen

  task automatic add_hdr(input logic [15:0] n);
    stream.delete();
    stream.push_back(n[15:8]);
    stream.push_back(n[7:0]);
  endtask

  task automatic add_word(input logic [31:0] w);
    stream.push_back(w[31:24]);
    stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
  endtask

  // Reference model: image word w lives at bytes 2+4w..5+4w and goes to address w.
  task automatic model();
    int  n;
    wr_t w;
    n = {stream[0], stream[1]};
    for (int k = 0; k < n; k++) begin
      w.addr = 16'(k);
      w.data = {stream[2 + 4 * k], stream[3 + 4 * k], stream[4 + 4 * k], stream[5 + 4 * k]};
      exp_q.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 1, 0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", wr_addr, w.addr);
        check("wr_data", wr_data, w.data);
        if (cyc_q.size() == 0) check("wr_timing_missing", 1, 0);
        else check("wr_cycle", cyc, cyc_q.pop_front());
      end
    end
  end

  // mode 0: continuous valid, 1: valid every other cycle, 2: random gaps.
  // rr: randomly pulse reload mid-load, which the loader must ignore.
  task automatic send(input int mode, input bit rr);
    int          i;
    int          budget;
    logic        v;
    logic        rdy;
    int unsigned k;
    i = 0;
    budget = 0;
    while (i < stream.size()) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = ($urandom % 3) != 0;
      endcase
      in_valid = v;
      in_byte  = v ? stream[i] : 8'($urandom);
      reload   = rr && (($urandom % 5) == 0);
      k   = cyc;
      rdy = in_ready;
      @(posedge clk);
      if (v && rdy) begin
        if (i >= 2 && ((i - 2) % 4) == 3) cyc_q.push_back(k + 1);
        i++;
      end
      budget++;
      if (budget > 20000) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic load(input int mode, input bit rr);
    int n;
    n = {stream[0], stream[1]};
    model();
    send(mode, rr);
    @(negedge clk);
    in_valid = 1'b0;
    reload   = 1'b0;
    if (n == 0) begin
      check("done_after_hdr", done, 1);
    end else begin
      check("last_wr_en", wr_en, 1);
      check("done_during_wr", done, 0);
      @(negedge clk);
      check("done", done, 1);
    end
    check("cpu_rst_f_done", cpu_rst_f, 1);
    check("in_ready_done", in_ready, 0);
    check("err_done", err, 0);
    check("pending_writes", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    reload   = 1'b0;
    @(negedge clk);
    exp_q.delete();
    cyc_q.delete();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cpu_rst_f", cpu_rst_f, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_done", done, 0);
    check("reload_cpu_rst_f", cpu_rst_f, 0);
    check("reload_in_ready", in_ready, 1);
    check("reload_err", err, 0);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    reload   = 1'b0;
    do_reset();

    // Two-word image, continuous valid.
    add_hdr(16'd2);
    add_word(32'hA1B2C3D4);
    add_word(32'h11223344);
    load(0, 1'b0);

    // Bytes offered after completion are ignored.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("done_holds", done, 1);
    check("in_ready_holds", in_ready, 0);

    do_reload();
    add_hdr(16'd1);
    add_word(32'hCAFEBABE);
    load(0, 1'b0);

    // Same two-word image with valid toggling.
    do_reload();
    add_hdr(16'd2);
    add_word(32'hA1B2C3D4);
    add_word(32'h11223344);
    load(1, 1'b0);

    // Empty image.
    do_reload();
    add_hdr(16'd0);
    load(0, 1'b0);

    // Partial load abandoned by reset, then a fresh image from address 0.
    do_reload();
    add_hdr(16'd2);
    stream.push_back(8'hA1);
    stream.push_back(8'hB2);
    send(0, 1'b0);
    do_reset();
    add_hdr(16'd1);
    add_word(32'hDEADBEEF);
    load(0, 1'b0);

    // Random images with random gaps and ignored mid-load reload pulses.
    for (int t = 0; t < 10; t++) begin
      do_reload();
      n = (t == 3) ? 0 : int'($urandom_range(1, 6));
      add_hdr(16'(n));
      for (int k = 0; k < n; k++) add_word($urandom);
      load(2, 1'b1);
    end

    // Longer image so addresses cross into the upper byte.
    do_reload();
    add_hdr(16'd300);
    for (int k = 0; k < 300; k++) add_word($urandom);
    load(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: in_byte  input  8  program stream byte.
REQ-004 SHALL have port: in_valid  input  1  in_byte valid.
REQ-005 SHALL have port: in_ready  output  1  loader accepts a byte; a byte transfers on any rising clk with in_valid=1 and in_ready=1.
REQ-006 SHALL have port: reload  input  1  restart-load request pulse.
REQ-007 SHALL have port: wr_en  output  1  instruction memory write strobe.
REQ-008 SHALL have port: wr_addr  output  16  instruction memory word address.
REQ-009 SHALL have port: wr_data  output  32  instruction word.
REQ-010 SHALL have port: cpu_rst_f  output  1  active-low processor reset; low while loading.
REQ-011 SHALL have port: done  output  1  load completed successfully.
REQ-012 SHALL have port: err  output  1  load failed (checksum build only).

Function
REQ-013 SHALL implement states HDR_HI, HDR_LO, DATA, WRITE, CSUM, DONE, ERR.
REQ-014 SHALL accept stream format: word count N (16-bit, MSB byte first), then N words of 4 bytes each, MSB first.
REQ-015 SHALL assert in_ready only in HDR_HI, HDR_LO, DATA, CSUM.
REQ-016 HDR_HI: on transfer, latch N[15:8] -> HDR_LO.
REQ-017 HDR_LO: on transfer, latch N[7:0]; if N=0 -> DONE (or CSUM when checksum compiled in), else -> DATA.
REQ-018 DATA: shift each transferred byte into a 32-bit assembly register; 2-bit byte index; after 4th byte -> WRITE.
REQ-019 WRITE: one cycle, wr_en=1, wr_data=assembled word, wr_addr=word counter; wr_en asserted exactly one cycle after the 4th-byte transfer.
REQ-020 After WRITE: if word counter = N-1 -> DONE (or CSUM), else increment word counter, byte index = 0 -> DATA.
REQ-021 Word addresses SHALL run 0..N-1 with no wrap; N=65535 writes address 65534 last.
REQ-022 wr_en SHALL be 0 in every state except WRITE; wr_addr/wr_data hold last values otherwise.
REQ-023 in_valid gaps SHALL stall the FSM without losing or duplicating bytes.
REQ-024 DONE: done=1, cpu_rst_f=1, in_ready=0; further in_valid ignored.
REQ-025 ERR: err=1, cpu_rst_f=0, in_ready=0.
REQ-026 reload=1 in DONE or ERR SHALL next cycle enter HDR_HI, clear done/err, drive cpu_rst_f=0, zero counters; reload ignored in all other states.

Reset
REQ-027 rst=1 SHALL, at the next rising clk, enter HDR_HI and set wr_en=0, wr_addr=0, wr_data=0, word counter=0, byte index=0, cpu_rst_f=0, done=0, err=0, checksum=0, in_ready=1 (combinational from state).
REQ-028 rst SHALL take priority over reload and any in-flight transfer; a partially loaded stream is abandoned and the next stream loads from address 0.

Configuration
REQ-029 Macro IM_LOADER_CSUM_EN defined: running XOR of all data bytes (not header); after last word (or N=0) CSUM accepts one byte; match -> DONE, mismatch -> ERR.
REQ-030 IM_LOADER_CSUM_EN undefined: no CSUM state, no checksum logic, err tied 0, completion goes directly to DONE.

Verification
REQ-031 Stream 00 02 A1 B2 C3 D4 11 22 33 44, in_valid continuous -> wr (0,A1B2C3D4), wr (1,11223344), then done=1, cpu_rst_f=1.
REQ-032 Stream 00 00 -> no wr_en, done=1 the cycle after 2nd byte (no CSUM build).
REQ-033 Same stream as REQ-031 with in_valid toggled every other cycle -> identical writes and final state.
REQ-034 rst pulsed after 00 02 A1 B2 -> all outputs at reset values; then 00 01 DE AD BE EF -> wr (0,DEADBEEF), done=1.
REQ-035 CSUM build: 00 01 01 02 04 08 then 0F -> done=1; with 0E instead -> err=1, cpu_rst_f=0.
REQ-036 reload pulse in DONE -> HDR_HI, done=0, cpu_rst_f=0, in_ready=1; next stream 00 01 CA FE BA BE -> wr (0,CAFEBABE).
